// File: rtl/i2s_tdm_tx.sv
// N-channel I2S/TDM serialiser with a frame FIFO and programmable bit clock.
// Define I2S_TDM_TX_HOLD_ON_UNDERRUN_EN to repeat the last frame on underrun.
module i2s_tdm_tx #(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [PRESCALE_W-1:0]          prescaler,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0]   in_data,
    output logic                           sclk,
    output logic                           lrclk,
    output logic                           sdata,
    output logic                           frame_start,
    output logic                           underrun,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    localparam int FB  = CHANNELS * SLOT_W;
    localparam int KW  = $clog2(FB);
    localparam int DW  = CHANNELS * SAMPLE_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int PAD = SLOT_W - SAMPLE_W;

    logic [PRESCALE_W-1:0] pc_q, pc_d, pmax;
    logic                  sclk_q, sclk_d;
    logic [KW-1:0]         k_q, k_d;
    logic [DW-1:0]         frame_q, frame_d, sh;
    logic                  sdata_q, sdata_d, lrclk_q, lrclk_d;
    logic                  fs_q, fs_d, ur_q, ur_d;
    logic [LW-1:0]         level_q, level_d;
    logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic                  rdy_q, rdy_d;
    logic                  tc, fall, wrap, push, pop;
    logic [DW-1:0]         mem [FIFO_DEPTH];
    int                    slot, pos, kn;

    always_comb begin
        pmax = (prescaler == '0) ? PRESCALE_W'(1) : prescaler;
        // >= so a prescaler shrunk below the running count still terminates
        tc     = (pc_q >= pmax - PRESCALE_W'(1));
        pc_d   = tc ? '0 : pc_q + PRESCALE_W'(1);
        sclk_d = tc ? ~sclk_q : sclk_q;
        fall   = tc && sclk_q;

        k_d  = k_q;
        wrap = 1'b0;
        if (fall) begin
            if (k_q == KW'(FB - 1)) begin
                k_d  = '0;
                wrap = 1'b1;
            end else begin
                k_d = k_q + KW'(1);
            end
        end

        push = in_valid && rdy_q;
        pop  = wrap && (level_q != '0);
        fs_d = wrap;
        ur_d = wrap && (level_q == '0);

        frame_d = frame_q;
        if (pop) begin
            frame_d = mem[rp_q];
        end else if (wrap) begin
`ifdef I2S_TDM_TX_HOLD_ON_UNDERRUN_EN
            frame_d = frame_q;
`else
            frame_d = '0;
`endif
        end

        wp_d    = push ? wp_q + AW'(1) : wp_q;
        rp_d    = pop ? rp_q + AW'(1) : rp_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        rdy_d = (level_d != LW'(FIFO_DEPTH));

        sdata_d = sdata_q;
        lrclk_d = lrclk_q;
        slot    = 0;
        pos     = 0;
        kn      = 0;
        sh      = '0;
        if (fall) begin
            slot    = int'(k_d) / SLOT_W;
            pos     = SLOT_W - 1 - (int'(k_d) % SLOT_W);
            sdata_d = 1'b0;
            if (pos >= PAD) begin
                sh      = frame_d >> (slot * SAMPLE_W + pos - PAD);
                sdata_d = sh[0];
            end
            // lrclk looks one bit ahead of the data
            kn      = (int'(k_d) + 1) % FB;
            lrclk_d = (kn / SLOT_W) >= (CHANNELS / 2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            sclk_q  <= 1'b0;
            k_q     <= KW'(FB - 1);
            frame_q <= '0;
            sdata_q <= 1'b0;
            lrclk_q <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            level_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            rdy_q   <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            sclk_q  <= sclk_d;
            k_q     <= k_d;
            frame_q <= frame_d;
            sdata_q <= sdata_d;
            lrclk_q <= lrclk_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
            level_q <= level_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= in_data;
        end
    end

    assign in_ready    = rdy_q;
    assign sclk        = sclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
    assign fifo_level  = level_q;
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Scoreboard bench for i2s_tdm_tx: stereo instance plus an 8-slot TDM instance.
// Expected bit streams are queued by stimulus and popped by a monitor.
module tb_i2s_tdm_tx;
    logic clk = 0;
    always #5 clk = ~clk;

    logic         a_rst = 0, b_rst = 0;
    logic [7:0]   a_pre = 8'd2, b_pre = 8'd1;
    logic         a_iv = 0, b_iv = 0;
    logic [31:0]  a_id = '0;
    logic [191:0] b_id = '0;
    logic a_rdy, a_sclk, a_lr, a_sd, a_fs, a_ur;
    logic b_rdy, b_sclk, b_lr, b_sd, b_fs, b_ur;
    logic [2:0] a_lvl, b_lvl;

    i2s_tdm_tx #(.CHANNELS(2), .SAMPLE_W(16), .SLOT_W(16),
                 .FIFO_DEPTH(4), .PRESCALE_W(8)) u_a (
        .clk(clk), .reset_n(a_rst), .prescaler(a_pre),
        .in_valid(a_iv), .in_ready(a_rdy), .in_data(a_id),
        .sclk(a_sclk), .lrclk(a_lr), .sdata(a_sd),
        .frame_start(a_fs), .underrun(a_ur), .fifo_level(a_lvl));

    i2s_tdm_tx #(.CHANNELS(8), .SAMPLE_W(24), .SLOT_W(32),
                 .FIFO_DEPTH(4), .PRESCALE_W(8)) u_b (
        .clk(clk), .reset_n(b_rst), .prescaler(b_pre),
        .in_valid(b_iv), .in_ready(b_rdy), .in_data(b_id),
        .sclk(b_sclk), .lrclk(b_lr), .sdata(b_sd),
        .frame_start(b_fs), .underrun(b_ur), .fifo_level(b_lvl));

    int checks = 0, failures = 0, nbits = 0;
    logic sel = 0, mon_en = 0, prev = 0;
    logic [1:0] expq[$];
    bit uq[$];

    wire m_sclk = sel ? b_sclk : a_sclk;
    wire m_sd   = sel ? b_sd : a_sd;
    wire m_lr   = sel ? b_lr : a_lr;
    wire m_fs   = sel ? b_fs : a_fs;
    wire m_ur   = sel ? b_ur : a_ur;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected slot stream: sample left-justified in slot, MSB first;
    // lrclk high from one bit before the second half to one bit before the end.
    function automatic void gen(input logic [255:0] f, input int ch,
                                input int sw, input int slw);
        int fb;
        logic [31:0] w;
        fb = ch * slw;
        for (int s = 0; s < ch; s++) begin
            w = 32'((f >> (s * sw)) & ((256'd1 << sw) - 1));
            w = w << (slw - sw);
            for (int j = 0; j < slw; j++) begin
                int k;
                logic b, lr;
                k  = s * slw + j;
                b  = w[slw - 1 - j];
                lr = (k >= fb / 2 - 1) && (k != fb - 1);
                expq.push_back({lr, b});
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [1:0] e;
        bit eu;
        if (mon_en) begin
            if (m_fs && uq.size() > 0) begin
                eu = uq.pop_front();
                chk("underrun_flag", 64'(m_ur), 64'(eu));
            end
            if (prev && !m_sclk && expq.size() > 0) begin
                e = expq.pop_front();
                chk("sdata", 64'(m_sd), 64'(e[0]));
                chk("lrclk", 64'(m_lr), 64'(e[1]));
                nbits++;
            end
        end
        prev = m_sclk;
    end

    task automatic drain(input int bound);
        int c;
        c = 0;
        while ((expq.size() != 0 || uq.size() != 0) && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("drain_left", 64'(expq.size() + uq.size()), 64'd0);
        expq.delete();
        uq.delete();
    endtask

    task automatic hold_reset;
        mon_en = 0;
        a_rst = 0;
        b_rst = 0;
        repeat (3) @(negedge clk);
        expq.delete();
        uq.delete();
    endtask

    initial begin
        int c, acc;
        // Idle: all underrun frames, zeros out
        a_pre = 8'd2;
        hold_reset();
        chk("rst_in_ready", 64'(a_rdy), 64'd1);
        chk("rst_sclk", 64'(a_sclk), 64'd0);
        chk("rst_lrclk", 64'(a_lr), 64'd0);
        chk("rst_sdata", 64'(a_sd), 64'd0);
        chk("rst_level", 64'(a_lvl), 64'd0);
        gen(256'd0, 2, 16, 16);
        gen(256'd0, 2, 16, 16);
        uq.push_back(1);
        uq.push_back(1);
        a_rst = 1;
        mon_en = 1;
        c = 0;
        do begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end while (!a_fs && c < 50);
        chk("first_load_cycle", 64'(c), 64'd4);
        c = 0;
        do begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end while (!a_ur && c < 300);
        chk("underrun_period", 64'(c), 64'd128);
        chk("idle_in_ready", 64'(a_rdy), 64'd1);
        drain(400);

        // Single frame then underrun
        hold_reset();
        a_iv = 1;
        a_id = 32'h1234_A5A5;
        gen(256'h1234_A5A5, 2, 16, 16);
`ifdef I2S_TDM_TX_HOLD_ON_UNDERRUN_EN
        gen(256'h1234_A5A5, 2, 16, 16);
`else
        gen(256'd0, 2, 16, 16);
`endif
        uq.push_back(0);
        uq.push_back(1);
        a_rst = 1;
        mon_en = 1;
        @(negedge clk);
        a_iv = 0;
        chk("level_after_push", 64'(a_lvl), 64'd1);
        drain(400);

        // Full FIFO with prescaler 8: first load at cycle 16
        a_pre = 8'd8;
        hold_reset();
        a_iv = 1;
        a_id = 32'h1111_1111;
        acc = 0;
        a_rst = 1;
        mon_en = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bit take;
            take = a_iv && a_rdy;
            if (take) begin
                acc++;
                gen(256'(a_id), 2, 16, 16);
                uq.push_back(0);
            end
            @(posedge clk);
            #1;
            if (take) begin
                a_id = 32'h1111_1111 * (acc + 1);
                if (acc == 5) a_iv = 0;
            end
            @(negedge clk);
            if (cyc == 3) begin
                chk("full_in_ready", 64'(a_rdy), 64'd0);
                chk("full_level", 64'(a_lvl), 64'd4);
            end
            if (cyc == 15) begin
                chk("pop_level", 64'(a_lvl), 64'd3);
                chk("pop_in_ready", 64'(a_rdy), 64'd1);
            end
            if (cyc == 16) begin
                chk("refill_level", 64'(a_lvl), 64'd4);
            end
        end
        chk("accepted", 64'(acc), 64'd5);
        uq.push_back(1);
        drain(4000);

        // Reset at bit 10 with two frames queued
        a_pre = 8'd2;
        hold_reset();
        a_iv = 1;
        a_id = 32'hDEAD_BEEF;
        gen(256'hDEAD_BEEF, 2, 16, 16);
        uq.push_back(0);
        a_rst = 1;
        mon_en = 1;
        @(negedge clk);
        a_id = 32'h0F0F_F0F0;
        @(negedge clk);
        a_iv = 0;
        chk("two_queued", 64'(a_lvl), 64'd2);
        c = 0;
        while (nbits < 0 + 10 + (nbits - nbits) && c < 0) c++;
        begin
            int n0;
            n0 = nbits;
            c = 0;
            while (nbits < n0 + 9 && c < 200) begin
                @(negedge clk);
                c++;
            end
        end
        chk("reach_bit10", 64'(c < 200), 64'd1);
        mon_en = 0;
        a_rst = 0;
        #1;
        chk("mid_sclk", 64'(a_sclk), 64'd0);
        chk("mid_lrclk", 64'(a_lr), 64'd0);
        chk("mid_sdata", 64'(a_sd), 64'd0);
        chk("mid_fs", 64'(a_fs), 64'd0);
        chk("mid_ur", 64'(a_ur), 64'd0);
        chk("mid_level", 64'(a_lvl), 64'd0);
        chk("mid_in_ready", 64'(a_rdy), 64'd1);
        expq.delete();
        uq.delete();
        gen(256'd0, 2, 16, 16);
        uq.push_back(1);
        repeat (2) @(negedge clk);
        a_rst = 1;
        mon_en = 1;
        drain(400);

        // TDM: 8 slots of 24-bit samples in 32-bit slots
        hold_reset();
        sel = 1;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            logic [31:0] v;
            v = 32'h0010_0010 * n + 1;
            b_id[n*24 +: 24] = v[23:0];
        end
        b_iv = 1;
        gen(256'(b_id), 8, 24, 32);
        uq.push_back(0);
        b_rst = 1;
        mon_en = 1;
        @(negedge clk);
        b_iv = 0;
        drain(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
